fetch_unit: RTL and testbench

Instruction prefetch stage sitting directly upstream of the core's IF/ID pipeline register. Issues in-order word fetches to a variable-latency instruction memory, buffers returned instructions with their PCs in a small FIFO, and presents them to the core with a valid/ready handshake. A redirect (branch/jump resolved in EX) flushes the buffer, discards in-flight responses and restarts fetch at the new PC.

---
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction prefetch stage: issues in-order word fetches under a credit limit,
// buffers returned words with their PCs, and hands them to the core; redirect flushes.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    input  logic        ins_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW:0]   credit_used;
    logic [31:0]   redirect_word;
    logic          req_fire;
    logic          resp_take;
    logic          push;
    logic          pop;

    // Buffered entries plus in-flight requests never exceed DEPTH, so a kept response always has room.
    assign credit_used   = {1'b0, count} + {1'b0, outstanding};
    assign mem_req_valid = !rst && !redirect && (credit_used < (CW+1)'(DEPTH));
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign resp_take     = mem_resp_valid && (outstanding != '0);
    assign push          = resp_take && (discard == '0);
    assign pop           = ins_valid && ins_ready;
    assign redirect_word = redirect_pc & ~32'd3;

    assign ins_valid = (count != '0);
    assign ins       = ins_valid ? ins_mem[rd_ptr] : '0;
    assign ins_pc    = ins_valid ? pc_mem[rd_ptr]  : '0;

    always_ff @(posedge clk) begin
        if (push && !redirect) begin
            ins_mem[wr_ptr] <= mem_resp_data;
            pc_mem[wr_ptr]  <= resp_pc;
        end
    end

    // Responses still in flight at a redirect belong to the old stream and are counted off via discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC & ~32'd3;
            resp_pc     <= RESET_PC & ~32'd3;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);
            if (redirect) begin
                fetch_pc <= redirect_word;
                resp_pc  <= redirect_word;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                discard  <= outstanding - CW'(resp_take);
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (resp_take && (discard != '0))
                    discard <= discard - CW'(1);
                if (push) begin
                    wr_ptr  <= wr_ptr + PW'(1);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model and
// request/pop logs compared against hand-computed address sequences.
`timescale 1ns/1ps
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memReqValid;
    logic [31:0] memReqAddr;
    logic        memReqReady = 1'b0;
    logic        memRespValid;
    logic [31:0] memRespData;
    logic        insValid;
    logic [31:0] ins;
    logic [31:0] insPc;
    logic        insReady = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pendT;

    pendT        pendQ[$];
    logic [31:0] reqLog[$];
    logic [31:0] popPcLog[$];
    logic [31:0] popInsLog[$];
    int          memLat = 1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_valid (memReqValid),
        .mem_req_addr  (memReqAddr),
        .mem_req_ready (memReqReady),
        .mem_resp_valid(memRespValid),
        .mem_resp_data (memRespData),
        .ins_valid     (insValid),
        .ins           (ins),
        .ins_pc        (insPc),
        .ins_ready     (insReady),
        .redirect      (redirect),
        .redirect_pc   (redirectPc)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] logAt(input logic [31:0] q[$], input int i);
        if (i < q.size())
            return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    // Memory samples handshakes mid-cycle and answers in order after memLat cycles.
    initial begin
        logic        sFire;
        logic        sPop;
        logic [31:0] sAddr;
        logic [31:0] sPc;
        logic [31:0] sIns;
        pendT        pe;
        memRespValid = 1'b0;
        memRespData  = 32'h0;
        forever begin
            @(negedge clk);
            sFire = memReqValid && memReqReady;
            sAddr = memReqAddr;
            sPop  = insValid && insReady && !redirect;
            sPc   = insPc;
            sIns  = ins;
            @(posedge clk);
            #1;
            if (rst) begin
                pendQ.delete();
                memRespValid = 1'b0;
                memRespData  = 32'h0;
            end else begin
                if (sFire) begin
                    pe.addr = sAddr;
                    pe.due  = cyc + memLat;
                    pendQ.push_back(pe);
                    reqLog.push_back(sAddr);
                end
                if (sPop) begin
                    popPcLog.push_back(sPc);
                    popInsLog.push_back(sIns);
                end
                cyc++;
                if (pendQ.size() != 0 && pendQ[0].due <= cyc) begin
                    pe = pendQ.pop_front();
                    memRespValid = 1'b1;
                    memRespData  = memWord(pe.addr);
                end else begin
                    memRespValid = 1'b0;
                    memRespData  = 32'h0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drives one cycle's inputs just after the edge, then waits to the sampling point.
    task automatic applyStimulus(input logic rdy, input logic mrdy, input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        insReady    = rdy;
        memReqReady = mrdy;
        redirect    = rd;
        redirectPc  = rpc;
        @(negedge clk);
    endtask

    task automatic resetDut(input int lat);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        insReady    = 1'b0;
        memReqReady = 1'b0;
        redirect    = 1'b0;
        redirectPc  = 32'h0;
        @(negedge clk);
        checkOutput("rst_ins_valid", insValid, 0);
        checkOutput("rst_req_valid", memReqValid, 0);
        checkOutput("rst_ins", ins, 0);
        checkOutput("rst_ins_pc", insPc, 0);
        reqLog.delete();
        popPcLog.delete();
        popInsLog.delete();
        memLat = lat;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        $display("[TB] fetch_unit directed test start");

        // Streaming from reset, then a redirect that coincides with a response.
        resetDut(1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput("stream_req_valid", memReqValid, 1);
            checkOutput("stream_req_addr", memReqAddr, 32'(4 * k));
            checkOutput("stream_ins_valid", insValid, (k >= 2) ? 1 : 0);
            checkOutput("stream_ins_pc", insPc, (k >= 2) ? 32'(4 * (k - 2)) : 32'h0);
            checkOutput("stream_ins", ins, (k >= 2) ? memWord(32'(4 * (k - 2))) : 32'h0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
        checkOutput("redir_req_blocked", memReqValid, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_fifo_empty", insValid, 0);
        checkOutput("redir_ins_zero", ins, 0);
        checkOutput("redir_req_addr", memReqAddr, 32'h40);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_still_empty", insValid, 0);
        checkOutput("redir_req_addr2", memReqAddr, 32'h44);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_first_valid", insValid, 1);
        checkOutput("redir_first_pc", insPc, 32'h40);
        checkOutput("redir_first_ins", ins, memWord(32'h40));

        // Core stalls: credits stop fetch at four, then drain in order.
        resetDut(1);
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("stall_req_count", 32'(reqLog.size()), 4);
        checkOutput("stall_req3", logAt(reqLog, 3), 32'hC);
        checkOutput("stall_req_valid", memReqValid, 0);
        checkOutput("stall_head_pc", insPc, 32'h0);
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("drain_pc0", logAt(popPcLog, 0), 32'h0);
        checkOutput("drain_pc1", logAt(popPcLog, 1), 32'h4);
        checkOutput("drain_pc2", logAt(popPcLog, 2), 32'h8);
        checkOutput("drain_pc3", logAt(popPcLog, 3), 32'hC);
        checkOutput("drain_pc4", logAt(popPcLog, 4), 32'h10);
        checkOutput("drain_ins3", logAt(popInsLog, 3), memWord(32'hC));
        checkOutput("resume_req", logAt(reqLog, 4), 32'h10);

        // Three-cycle memory with requests in flight, redirect to an unaligned PC.
        resetDut(3);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("lat3_req0", memReqAddr, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("lat3_req1", memReqAddr, 32'h4);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("lat3_req2", memReqAddr, 32'h8);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h103);
        checkOutput("lat3_redir_blocked", memReqValid, 0);
        reqLog.delete();
        popPcLog.delete();
        popInsLog.delete();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("lat3_new_valid", memReqValid, 1);
        checkOutput("lat3_new_addr", memReqAddr, 32'h100);
        checkOutput("lat3_empty", insValid, 0);
        repeat (15) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("lat3_pop_pc0", logAt(popPcLog, 0), 32'h100);
        checkOutput("lat3_pop_ins0", logAt(popInsLog, 0), memWord(32'h100));
        checkOutput("lat3_pop_pc1", logAt(popPcLog, 1), 32'h104);
        checkOutput("lat3_pop_ins1", logAt(popInsLog, 1), memWord(32'h104));
        checkOutput("lat3_pop_pc2", logAt(popPcLog, 2), 32'h108);

        // Address wrap past the top of the 32-bit space.
        resetDut(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        checkOutput("wrap_redir_blocked", memReqValid, 0);
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("wrap_req0", logAt(reqLog, 0), 32'hFFFF_FFF8);
        checkOutput("wrap_req1", logAt(reqLog, 1), 32'hFFFF_FFFC);
        checkOutput("wrap_req2", logAt(reqLog, 2), 32'h0);
        checkOutput("wrap_pc0", logAt(popPcLog, 0), 32'hFFFF_FFF8);
        checkOutput("wrap_pc1", logAt(popPcLog, 1), 32'hFFFF_FFFC);
        checkOutput("wrap_pc2", logAt(popPcLog, 2), 32'h0);
        checkOutput("wrap_ins2", logAt(popInsLog, 2), memWord(32'h0));

        // Reset while two entries are buffered and one request is outstanding.
        resetDut(1);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("mid_pre_valid", insValid, 1);
        checkOutput("mid_pre_addr", memReqAddr, 32'h8);
        resetDut(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("mid_post_req_valid", memReqValid, 1);
        checkOutput("mid_post_req_addr", memReqAddr, 32'h0);
        checkOutput("mid_post_empty", insValid, 0);
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("mid_pop_pc0", logAt(popPcLog, 0), 32'h0);
        checkOutput("mid_pop_ins0", logAt(popInsLog, 0), memWord(32'h0));
        checkOutput("mid_pop_pc2", logAt(popPcLog, 2), 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
